// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// Program-counter stage fed by the branch-decision (PCSel) logic. Holds the
// architectural PC, presents it to instruction memory through a req/ready
// handshake, and on each accepted fetch advances to PC+4 or to the branch
// target. A taken branch to a non-word-aligned target halts the core with a
// sticky error flag. Accepted fetches are counted.
//
// Ports
//   clk            in   system clock, rising-edge active
//   rst_n          in   synchronous active-low reset
//   pc_sel         in   branch taken (Branch AND Zero)
//   branch_imm     in   sign-extended branch offset, before the shift
//   stall          in   hazard hold, blocks PC advance
//   imem_ready     in   instruction memory accepts the fetch address
//   imem_req       out  fetch request valid (high only in FETCH)
//   pc_out         out  current PC / fetch address
//   pc_plus4       out  pc_out + 4, wrapping
//   branch_target  out  pc_out + (branch_imm << IMM_SHIFT), wrapping
//   misalign_err   out  sticky misaligned-branch error
//   fetch_count    out  number of accepted fetches, wrapping
// -----------------------------------------------------------------------------
module pc_next_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     IMM_SHIFT    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] branch_imm,
    input  logic            stall,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] branch_target,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    // Instruction fetch addresses must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            req_q, req_d;

    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] imm_shifted_s;
    logic [XLEN-1:0] branch_target_s;
    logic            accept_s;
    logic            target_ok_s;

    // Address arithmetic; the shift drops the top IMM_SHIFT bits and both adds wrap.
    always_comb begin
        pc_plus4_s      = pc_q + PC_STEP;
        imm_shifted_s   = branch_imm << IMM_SHIFT;
        branch_target_s = pc_q + imm_shifted_s;
        target_ok_s     = is_word_aligned(branch_target_s);
        // stall wins over ready; accepts only happen while requesting
        accept_s        = (state_q == ST_FETCH) && imem_ready && !stall;
    end

    // Next-state logic of the fetch FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (accept_s && pc_sel && !target_ok_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Datapath next values: PC, fetch counter and sticky error.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        err_d   = err_q;
        if (accept_s) begin
            // the fetch at the current PC completed regardless of where we go next
            count_d = count_q + 32'd1;
            if (!pc_sel) begin
                pc_d = pc_plus4_s;
            end else if (target_ok_s) begin
                pc_d = branch_target_s;
            end else begin
                pc_d  = pc_q;
                err_d = 1'b1;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Output decode from the upcoming state so imem_req is registered yet aligned with state.
    always_comb begin
        req_d = 1'b0;
        case (state_d)
            ST_FETCH: req_d = 1'b1;
            ST_BOOT:  req_d = 1'b0;
            ST_HALT:  req_d = 1'b0;
            default:  req_d = 1'b0;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            count_q <= 32'd0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    assign imem_req      = req_q;
    assign pc_out        = pc_q;
    assign pc_plus4      = pc_plus4_s;
    assign branch_target = branch_target_s;
    assign misalign_err  = err_q;
    assign fetch_count   = count_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_next_unit
//
// Directed bench for pc_next_unit. Inputs change and outputs are sampled 1 ns
// after each rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_sel;
    logic [31:0] branch_imm;
    logic        stall;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int total;
    int bad;

    pc_next_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .IMM_SHIFT(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_sel(pc_sel),
        .branch_imm(branch_imm),
        .stall(stall),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .pc_out(pc_out),
        .pc_plus4(pc_plus4),
        .branch_target(branch_target),
        .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_sel = 1'b0; branch_imm = 32'h0; stall = 1'b0; imem_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_out, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", misalign_err); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", fetch_count); end
        rst_n = 1'b1;
        #1;
        // cycle 0 after release: still BOOT
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL fetch1 req=%b pc=%h exp req=1 pc=0", imem_req, pc_out); end
        total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL plus4 got=%h exp=%h", pc_plus4, 32'h4); end
        tick();
        total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL seq_c2 got=%h exp=%h", pc_out, 32'h4); end
        tick();
        total++; if (pc_out !== 32'h8) begin bad++; $display("FAIL seq_c3 got=%h exp=%h", pc_out, 32'h8); end
        tick();
        total++; if (pc_out !== 32'hC) begin bad++; $display("FAIL seq_c4 got=%h exp=%h", pc_out, 32'hC); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL cnt_c4 got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_handshake();
        tick();  // 0xC -> 0x10, count 4
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_sel     = (i == 2) ? 1'b1 : 1'b0;
            branch_imm = 32'h0000_0100;
            #1;
            total++; if (pc_out !== 32'h10 || imem_req !== 1'b1) begin bad++; $display("FAIL hold_%0d pc=%h req=%b exp pc=10 req=1", i, pc_out, imem_req); end
            tick();
        end
        total++; if (pc_out !== 32'h10 || fetch_count !== 32'd4) begin bad++; $display("FAIL hold_end pc=%h cnt=%0d exp pc=10 cnt=4", pc_out, fetch_count); end
        imem_ready = 1'b1; pc_sel = 1'b0;
        tick();
        total++; if (pc_out !== 32'h14) begin bad++; $display("FAIL ready_adv got=%h exp=%h", pc_out, 32'h14); end
    endtask

    task automatic test_branch();
        tick(); tick(); tick();  // 0x18, 0x1C, 0x20; count 8
        pc_sel = 1'b1; branch_imm = 32'hFFFF_FFF8;
        #1;
        total++; if (branch_target !== 32'h10) begin bad++; $display("FAIL bt_back got=%h exp=%h", branch_target, 32'h10); end
        tick();
        total++; if (pc_out !== 32'h10 || fetch_count !== 32'd9) begin bad++; $display("FAIL br_back pc=%h cnt=%0d exp pc=10 cnt=9", pc_out, fetch_count); end
        pc_sel = 1'b0;
        tick(); tick(); tick(); tick();  // 0x14..0x20; count 13
        pc_sel = 1'b1; branch_imm = 32'h0000_0040;
        #1;
        total++; if (branch_target !== 32'hA0) begin bad++; $display("FAIL bt_fwd got=%h exp=%h", branch_target, 32'hA0); end
        tick();
        total++; if (pc_out !== 32'hA0 || fetch_count !== 32'd14) begin bad++; $display("FAIL br_fwd pc=%h cnt=%0d exp pc=a0 cnt=14", pc_out, fetch_count); end
    endtask

    task automatic test_stall();
        pc_sel = 1'b1; branch_imm = 32'hFFFF_FFD0;  // 0xA0 - 0x60 = 0x40
        tick();
        total++; if (pc_out !== 32'h40) begin bad++; $display("FAIL st_setup got=%h exp=%h", pc_out, 32'h40); end
        stall = 1'b1; imem_ready = 1'b1; pc_sel = 1'b1; branch_imm = 32'h0000_0010;
        tick(); tick();
        total++; if (pc_out !== 32'h40 || fetch_count !== 32'd15) begin bad++; $display("FAIL st_hold pc=%h cnt=%0d exp pc=40 cnt=15", pc_out, fetch_count); end
        stall = 1'b0; pc_sel = 1'b0;
        tick();
        total++; if (pc_out !== 32'h44 || fetch_count !== 32'd16) begin bad++; $display("FAIL st_rel pc=%h cnt=%0d exp pc=44 cnt=16", pc_out, fetch_count); end
    endtask

    task automatic test_misalign();
        pc_sel = 1'b1; branch_imm = 32'hFFFF_FFE2;  // 0x44 - 0x3C = 0x08
        tick();
        total++; if (pc_out !== 32'h8) begin bad++; $display("FAIL ma_setup got=%h exp=%h", pc_out, 32'h8); end
        branch_imm = 32'h0000_0001;
        #1;
        total++; if (branch_target !== 32'hA) begin bad++; $display("FAIL ma_bt got=%h exp=%h", branch_target, 32'hA); end
        tick();
        total++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h8) begin bad++; $display("FAIL ma_halt err=%b req=%b pc=%h exp err=1 req=0 pc=8", misalign_err, imem_req, pc_out); end
        total++; if (fetch_count !== 32'd18) begin bad++; $display("FAIL ma_cnt got=%0d exp=18", fetch_count); end
        pc_sel = 1'b0; branch_imm = 32'h0000_0004;
        tick(); stall = 1'b1; tick(); stall = 1'b0; pc_sel = 1'b1; tick();
        total++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h8 || fetch_count !== 32'd18) begin bad++; $display("FAIL ma_frozen err=%b req=%b pc=%h cnt=%0d exp 1 0 8 18", misalign_err, imem_req, pc_out, fetch_count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; pc_sel = 1'b0;
        #1;
        total++; if (misalign_err !== 1'b0 || pc_out !== 32'h0 || fetch_count !== 32'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL ma_clear err=%b pc=%h cnt=%0d req=%b exp 0 0 0 0", misalign_err, pc_out, fetch_count, imem_req); end
    endtask

    task automatic test_wrap();
        tick();  // BOOT -> FETCH, pc 0
        pc_sel = 1'b1; branch_imm = 32'h7FFF_FFFE;  // top bit shifted out -> 0xFFFF_FFFC
        #1;
        total++; if (branch_target !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_bt got=%h exp=%h", branch_target, 32'hFFFF_FFFC); end
        tick();
        total++; if (pc_out !== 32'hFFFF_FFFC || misalign_err !== 1'b0) begin bad++; $display("FAIL wr_top pc=%h err=%b exp pc=fffffffc err=0", pc_out, misalign_err); end
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wr_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
        pc_sel = 1'b0;
        tick();
        total++; if (pc_out !== 32'h0 || misalign_err !== 1'b0 || imem_req !== 1'b1 || fetch_count !== 32'd2) begin bad++; $display("FAIL wr_adv pc=%h err=%b req=%b cnt=%0d exp 0 0 1 2", pc_out, misalign_err, imem_req, fetch_count); end
    endtask

    task automatic test_back_to_back();
        // consecutive taken branches then reset in mid-fetch
        pc_sel = 1'b1; branch_imm = 32'h0000_0008;  // 0x0 -> 0x10
        tick();
        total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL b2b_1 got=%h exp=%h", pc_out, 32'h10); end
        branch_imm = 32'hFFFF_FFFC;  // 0x10 - 8 -> 0x08
        tick();
        total++; if (pc_out !== 32'h8 || fetch_count !== 32'd4) begin bad++; $display("FAIL b2b_2 pc=%h cnt=%0d exp pc=8 cnt=4", pc_out, fetch_count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (pc_out !== 32'h0 || fetch_count !== 32'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL midrst pc=%h cnt=%0d req=%b exp 0 0 0", pc_out, fetch_count, imem_req); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_handshake();
        test_branch();
        test_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
